// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pipe
// Brief    : RISC-V immediate decoder feeding a 2-entry result FIFO with tag
// Revision : 1.0 - initial release
// ============================================================================
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [24:0]      in_din,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    localparam logic [1:0] c_DEPTH = 2'd2;

    logic [31:0]      w_inst;
    logic [XLEN-1:0]  w_imm;
    logic             w_err;
    logic             w_push;
    logic             w_pop;

    logic [XLEN-1:0]  r_imm [2];
    logic [TAG_W-1:0] r_tag [2];
    logic             r_err [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;

    // Rebuild the instruction word so the decode reads in instruction-bit terms.
    assign w_inst = {in_din, 7'b0000000};

    always_comb begin
        w_imm = '0;
        w_err = 1'b0;
        case (in_op)
            3'b000: w_imm = XLEN'($signed(w_inst[31:20]));
            3'b001: begin
                if (XLEN == 32) begin
                    w_imm = XLEN'(w_inst[24:20]);
                    w_err = w_inst[25];
                end else begin
                    w_imm = XLEN'(w_inst[25:20]);
                end
            end
            3'b010: w_imm = XLEN'($signed({w_inst[31:25], w_inst[11:7]}));
            3'b011: w_imm = XLEN'($signed({w_inst[31], w_inst[7], w_inst[30:25],
                                           w_inst[11:8], 1'b0}));
            3'b100: w_imm = XLEN'($signed({w_inst[31:12], 12'h000}));
            3'b101: w_imm = XLEN'($signed({w_inst[31], w_inst[19:12], w_inst[20],
                                           w_inst[30:21], 1'b0}));
            3'b110: w_imm = XLEN'(w_inst[19:15]);
            default: w_err = 1'b1;
        endcase
    end

    assign in_ready  = (r_count < c_DEPTH);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 2'd0;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_imm[i] <= '0;
                r_tag[i] <= '0;
                r_err[i] <= 1'b0;
            end
        end else if (flush) begin
            // Same-cycle push and pop are dropped along with the stored entries.
            r_count <= 2'd0;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
        end else begin
            if (w_push) begin
                r_imm[r_wptr] <= w_imm;
                r_tag[r_wptr] <= in_tag;
                r_err[r_wptr] <= w_err;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head entry only, gated to zero when the buffer is empty.
    assign out_imm = out_valid ? r_imm[r_rptr] : '0;
    assign out_tag = out_valid ? r_tag[r_rptr] : '0;
    assign out_err = out_valid ? r_err[r_rptr] : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_gen_pipe
// Brief    : scoreboard bench for imm_gen_pipe at XLEN=32 and XLEN=64
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        flush, in_valid, in_ready, out_valid, out_ready, out_err;
    logic [2:0]  in_op;
    logic [24:0] in_din;
    logic [4:0]  in_tag, out_tag;
    logic [31:0] out_imm;

    logic        flush64, in_valid64, in_ready64, out_valid64, out_ready64, out_err64;
    logic [2:0]  in_op64;
    logic [24:0] in_din64;
    logic [4:0]  in_tag64, out_tag64;
    logic [63:0] out_imm64;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_din(in_din),
        .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_tag(out_tag), .out_err(out_err)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .rst(rst), .flush(flush64),
        .in_valid(in_valid64), .in_ready(in_ready64), .in_op(in_op64), .in_din(in_din64),
        .in_tag(in_tag64), .out_valid(out_valid64), .out_ready(out_ready64),
        .out_imm(out_imm64), .out_tag(out_tag64), .out_err(out_err64)
    );

    typedef struct packed {
        logic [63:0] imm;
        logic [4:0]  tag;
        logic        err;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] inst, input logic [4:0] tag,
                        input logic [63:0] eimm, input logic eerr);
        exp_t e;
        int   n = 0;
        bit   done = 0;
        in_valid = 1'b1; in_op = op; in_din = inst[31:7]; in_tag = tag;
        while (!done && n < 50) begin
            @(negedge clk);
            if (in_ready && !flush && !rst) begin
                e.imm = eimm; e.tag = tag; e.err = eerr;
                q32.push_back(e);
                done = 1;
            end
            @(posedge clk); #1;
            n++;
        end
        if (!done) chk("send32_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic send64(input logic [2:0] op, input logic [31:0] inst, input logic [4:0] tag,
                          input logic [63:0] eimm, input logic eerr);
        exp_t e;
        int   n = 0;
        bit   done = 0;
        in_valid64 = 1'b1; in_op64 = op; in_din64 = inst[31:7]; in_tag64 = tag;
        while (!done && n < 50) begin
            @(negedge clk);
            if (in_ready64 && !flush64 && !rst) begin
                e.imm = eimm; e.tag = tag; e.err = eerr;
                q64.push_back(e);
                done = 1;
            end
            @(posedge clk); #1;
            n++;
        end
        if (!done) chk("send64_timeout", 64'd0, 64'd1);
        in_valid64 = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q32.size() != 0 || q64.size() != 0) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("drain_timeout", 64'd0, 64'd1);
    endtask

    // Monitor for the 32-bit instance: pops on transfer, checks hold under backpressure.
    initial begin
        exp_t e;
        exp_t prev;
        bit   held = 0;
        forever begin
            @(negedge clk);
            if (rst || flush) begin
                q32.delete();
                held = 0;
            end else if (out_valid && out_ready) begin
                held = 0;
                if (q32.size() == 0) begin
                    chk("spurious32", 64'(out_valid), 64'd0);
                end else begin
                    e = q32.pop_front();
                    chk("imm32", 64'(out_imm), e.imm);
                    chk("tag32", 64'(out_tag), 64'(e.tag));
                    chk("err32", 64'(out_err), 64'(e.err));
                end
            end else if (out_valid) begin
                if (held) begin
                    chk("hold_imm32", 64'(out_imm), prev.imm);
                    chk("hold_tag32", 64'(out_tag), 64'(prev.tag));
                end
                prev.imm = 64'(out_imm); prev.tag = out_tag; prev.err = out_err;
                held = 1;
            end else begin
                held = 0;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                q64.delete();
            end else if (out_valid64 && out_ready64) begin
                if (q64.size() == 0) begin
                    chk("spurious64", 64'(out_valid64), 64'd0);
                end else begin
                    e = q64.pop_front();
                    chk("imm64", out_imm64, e.imm);
                    chk("tag64", 64'(out_tag64), 64'(e.tag));
                    chk("err64", 64'(out_err64), 64'(e.err));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_din = '0; in_tag = '0;
        out_ready = 1'b1;
        flush64 = 1'b0; in_valid64 = 1'b0; in_op64 = '0; in_din64 = '0; in_tag64 = '0;
        out_ready64 = 1'b1;
        #3;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_imm", 64'(out_imm), 64'd0);
        chk("rst_valid64", 64'(out_valid64), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // First request lands on the first edge after reset release; 1-cycle latency.
        send(3'b000, 32'hFFF00093, 5'd3, 32'hFFFFFFFF, 1'b0);
        chk("lat_valid", 64'(out_valid), 64'd1);
        chk("lat_imm", 64'(out_imm), 64'hFFFFFFFF);
        chk("lat_tag", 64'(out_tag), 64'd3);
        send(3'b011, 32'hFE000EE3, 5'd4, 32'hFFFFFFFC, 1'b0);
        send(3'b101, 32'h0080006F, 5'd5, 32'h00000008, 1'b0);
        send(3'b010, 32'hFE0002A3, 5'd6, 32'hFFFFFFE5, 1'b0);
        send(3'b100, 32'h123450B7, 5'd7, 32'h12345000, 1'b0);
        send(3'b001, 32'h03F09093, 5'd8, 32'd31, 1'b1);
        send(3'b001, 32'h00509093, 5'd9, 32'd5, 1'b0);
        send(3'b110, 32'h000F8073, 5'd10, 32'd31, 1'b0);
        send(3'b111, 32'hFFFFFFFF, 5'h15, 32'd0, 1'b1);
        send(3'b000, 32'h7FF00013, 5'd11, 32'h000007FF, 1'b0);
        drain();

        // Backpressure: two fill the buffer, the third waits for a pop.
        out_ready = 1'b0;
        send(3'b000, 32'h7FF00013, 5'd1, 32'h000007FF, 1'b0);
        send(3'b010, 32'hFE0002A3, 5'd2, 32'hFFFFFFE5, 1'b0);
        @(negedge clk);
        chk("bp_ready", 64'(in_ready), 64'd0);
        chk("bp_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        fork
            send(3'b100, 32'h123450B7, 5'd3, 32'h12345000, 1'b0);
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Flush with a full buffer and a request offered in the same cycle.
        out_ready = 1'b0;
        send(3'b000, 32'h00100093, 5'd4, 32'd1, 1'b0);
        send(3'b010, 32'hFE0002A3, 5'd5, 32'hFFFFFFE5, 1'b0);
        in_valid = 1'b1; in_op = 3'b000; in_din = 25'h1FFFFFF; in_tag = 5'd6; flush = 1'b1;
        @(negedge clk);
        chk("flush_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_imm", 64'(out_imm), 64'd0);
        chk("flush_tag", 64'(out_tag), 64'd0);
        chk("flush_ready_after", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        send(3'b111, 32'h12345678, 5'h15, 32'd0, 1'b1);
        drain();

        // Asynchronous reset mid-stream.
        out_ready = 1'b0;
        send(3'b100, 32'h123450B7, 5'd6, 32'h12345000, 1'b0);
        send(3'b110, 32'h000F8073, 5'd7, 32'd31, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_imm", 64'(out_imm), 64'd0);
        chk("arst_tag", 64'(out_tag), 64'd0);
        chk("arst_err", 64'(out_err), 64'd0);
        chk("arst_ready", 64'(in_ready), 64'd1);
        q32.delete();
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("arst_no_stale", 64'(out_valid), 64'd0);
        send(3'b000, 32'h7FF00013, 5'd9, 32'h000007FF, 1'b0);
        drain();

        // 64-bit instance.
        send64(3'b100, 32'h800000B7, 5'd1, 64'hFFFFFFFF80000000, 1'b0);
        send64(3'b001, 32'h03F09093, 5'd2, 64'd63, 1'b0);
        send64(3'b000, 32'hFFF00093, 5'd3, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        send64(3'b011, 32'hFE000EE3, 5'd4, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        send64(3'b111, 32'h12345678, 5'd5, 64'd0, 1'b1);
        drain();

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate output width; legal values are 32 and 64.
REQ-002 SHALL have parameter TAG_W, default 5, sideband tag width carried alongside each request.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port flush  input  1  synchronous discard of all buffered entries.
REQ-006 SHALL have port in_valid  input  1  request present.
REQ-007 SHALL have port in_ready  output  1  request accepted this cycle when in_valid=1.
REQ-008 SHALL have port in_op  input  3  format select.
REQ-009 SHALL have port in_din  input  25  instruction bits [31:7] (in_din[k] = inst[k+7]).
REQ-010 SHALL have port in_tag  input  TAG_W  sideband, returned unchanged.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port out_imm  output  XLEN  decoded immediate.
REQ-014 SHALL have port out_tag  output  TAG_W  tag of the presented result.
REQ-015 SHALL have port out_err  output  1  illegal format or illegal shamt.

Function
REQ-016 SHALL decode the immediate by in_op, with results below given in instruction-bit terms and sign-extended from the top bit shown to XLEN.
- 000 I: inst[31:20].
- 001 shamt: zero-extended; inst[24:20] when XLEN=32, inst[25:20] when XLEN=64.
- 010 S: {inst[31:25], inst[11:7]}.
- 011 B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
- 100 U: {inst[31:12], 12'b0}.
- 101 J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
- 110 Z: inst[19:15], zero-extended (CSR zimm).
- 111: imm=0, err=1.
REQ-017 SHALL set err=1 for op 001 when XLEN=32 and inst[25]=1; imm is still the 5-bit value.
REQ-018 SHALL decode at input and store {imm, tag, err} in a 2-entry FIFO; out_* SHALL be driven from the head entry only, never combinationally from in_*.
REQ-019 SHALL give a latency of 1 cycle: a request accepted into an empty buffer at edge N has out_valid=1 after edge N.
REQ-020 SHALL drive in_ready = (count < 2), independent of out_ready.
REQ-021 SHALL push on in_valid & in_ready and pop on out_valid & out_ready; count is 0..2 and out_valid = (count != 0).
REQ-022 SHALL leave count unchanged on a simultaneous push and pop at count=1, with the new entry becoming head after the pop.
REQ-023 SHALL keep out_imm, out_tag and out_err stable while out_valid=1 and out_ready=0.
REQ-024 SHALL deliver results strictly in acceptance order.
REQ-025 SHALL, on flush=1, set count to 0 at the next edge, discard any same-cycle push and pop, and drive in_ready per the pre-flush count that cycle.
REQ-026 SHALL drive outputs of 0 from unoccupied entries when out_valid=0.

Reset
REQ-027 SHALL, while rst=1, immediately force count=0, out_valid=0, out_imm=0, out_tag=0, out_err=0 and in_ready=1, with storage pointers at 0.
REQ-028 SHALL let rst asserted mid-transfer drop all buffered entries, with no result emitted after deassertion.
REQ-029 SHALL accept the first request at the first rising edge after rst deasserts.

Verification
REQ-030 SHALL pass this I-type check: XLEN=32, op=000, inst=0xFFF00093, tag=3, out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFF, tag=3, err=0.
REQ-031 SHALL pass this B-type check: op=011, inst=0xFE000EE3 -> imm=0xFFFFFFFC; J-type op=101, inst=0x0080006F -> imm=0x00000008.
REQ-032 SHALL pass this XLEN=64 check: op=100, inst=0x800000B7 -> imm=0xFFFFFFFF80000000; op=001, inst=0x03F09093 -> imm=63, err=0; the same shamt at XLEN=32 -> imm=31, err=1.
REQ-033 SHALL pass this backpressure check: out_ready=0, three back-to-back requests -> first two accepted, in_ready=0 at count=2; then out_ready=1 -> results in order, third accepted once count<2.
REQ-034 SHALL pass this flush/reset check: flush at count=2 with in_valid=1 -> next cycle out_valid=0, count=0; rst pulse mid-stream -> all outputs 0 immediately, no stale results afterward.
REQ-035 SHALL pass this illegal-op check: op=111 with any inst -> imm=0, err=1, tag preserved.
